// File: rtl/adder_result_checker.sv
// Response-side checker for the ripple adder: recomputes a+b+cin, compares it with the
// adder's {cout,sum} and keeps pass/fail totals plus a snapshot of the first failing vector.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start, no vectors accepted
// S_RUN   | in_ready high, accepting vectors until the last index
// S_DRAIN | last vector is in the compare stage, no new accepts
// S_DONE  | totals final, done held until start or rst
module adder_result_checker #(
    parameter int WIDTH       = 4,
    parameter int CNT_W       = 8,
    parameter int NUM_VECTORS = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             cout_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             all_pass_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    output logic             err_o,
    output logic [CNT_W-1:0] ff_idx_o,
    output logic [WIDTH-1:0] ff_a_o,
    output logic [WIDTH-1:0] ff_b_o,
    output logic             ff_cin_o,
    output logic [WIDTH:0]   ff_got_o,
    output logic [WIDTH:0]   ff_exp_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s1_cin_q, s1_cin_d;
    logic [WIDTH:0]   s1_got_q, s1_got_d;
    logic [WIDTH:0]   s1_exp_q, s1_exp_d;
    logic [CNT_W-1:0] s1_idx_q, s1_idx_d;

    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
    logic [WIDTH-1:0] ff_a_q, ff_a_d;
    logic [WIDTH-1:0] ff_b_q, ff_b_d;
    logic             ff_cin_q, ff_cin_d;
    logic [WIDTH:0]   ff_got_q, ff_got_d;
    logic [WIDTH:0]   ff_exp_q, ff_exp_d;
    logic             all_pass_q, all_pass_d;

    logic             accept;
    logic             start_run;

    always_comb begin
        state_d    = state_q;
        s1_valid_d = 1'b0;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_cin_d   = s1_cin_q;
        s1_got_d   = s1_got_q;
        s1_exp_d   = s1_exp_q;
        s1_idx_d   = s1_idx_q;
        idx_d      = idx_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        err_d      = err_q;
        ff_idx_d   = ff_idx_q;
        ff_a_d     = ff_a_q;
        ff_b_d     = ff_b_q;
        ff_cin_d   = ff_cin_q;
        ff_got_d   = ff_got_q;
        ff_exp_d   = ff_exp_q;

        accept    = (state_q == S_RUN) && in_valid_i;
        start_run = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

        case (state_q)
            S_IDLE:  if (start_run) state_d = S_RUN;
            S_RUN:   if (accept && (idx_q == LAST_IDX)) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  if (start_run) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase

        // Stage 1: capture the vector and the reference result at full width.
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = a_i;
            s1_b_d     = b_i;
            s1_cin_d   = cin_i;
            s1_got_d   = {cout_i, sum_i};
            s1_exp_d   = {1'b0, a_i} + {1'b0, b_i} + (WIDTH + 1)'(cin_i);
            s1_idx_d   = idx_q;
            idx_d      = idx_q + CNT_ONE;
        end

        // Stage 2: compare and update totals; only the first failure is snapshotted.
        if (s1_valid_q) begin
            if (s1_got_q == s1_exp_q) begin
                if (pass_q != CNT_MAX) pass_d = pass_q + CNT_ONE;
            end else begin
                if (fail_q != CNT_MAX) fail_d = fail_q + CNT_ONE;
                if (!err_q) begin
                    err_d    = 1'b1;
                    ff_idx_d = s1_idx_q;
                    ff_a_d   = s1_a_q;
                    ff_b_d   = s1_b_q;
                    ff_cin_d = s1_cin_q;
                    ff_got_d = s1_got_q;
                    ff_exp_d = s1_exp_q;
                end
            end
        end

        if (start_run) begin
            idx_d    = '0;
            pass_d   = '0;
            fail_d   = '0;
            err_d    = 1'b0;
            ff_idx_d = '0;
            ff_a_d   = '0;
            ff_b_d   = '0;
            ff_cin_d = 1'b0;
            ff_got_d = '0;
            ff_exp_d = '0;
        end

        all_pass_d = (state_d == S_DONE) && (fail_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_cin_q   <= 1'b0;
            s1_got_q   <= '0;
            s1_exp_q   <= '0;
            s1_idx_q   <= '0;
            idx_q      <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            err_q      <= 1'b0;
            ff_idx_q   <= '0;
            ff_a_q     <= '0;
            ff_b_q     <= '0;
            ff_cin_q   <= 1'b0;
            ff_got_q   <= '0;
            ff_exp_q   <= '0;
            all_pass_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_cin_q   <= s1_cin_d;
            s1_got_q   <= s1_got_d;
            s1_exp_q   <= s1_exp_d;
            s1_idx_q   <= s1_idx_d;
            idx_q      <= idx_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            err_q      <= err_d;
            ff_idx_q   <= ff_idx_d;
            ff_a_q     <= ff_a_d;
            ff_b_q     <= ff_b_d;
            ff_cin_q   <= ff_cin_d;
            ff_got_q   <= ff_got_d;
            ff_exp_q   <= ff_exp_d;
            all_pass_q <= all_pass_d;
        end
    end

    assign in_ready_o = (state_q == S_RUN);
    assign busy_o     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_o     = (state_q == S_DONE);
    assign all_pass_o = all_pass_q;
    assign pass_cnt_o = pass_q;
    assign fail_cnt_o = fail_q;
    assign err_o      = err_q;
    assign ff_idx_o   = ff_idx_q;
    assign ff_a_o     = ff_a_q;
    assign ff_b_o     = ff_b_q;
    assign ff_cin_o   = ff_cin_q;
    assign ff_got_o   = ff_got_q;
    assign ff_exp_o   = ff_exp_q;

endmodule

// File: doc/adder_result_checker.md
Name: adder_result_checker

Overview:
- Response-side consumer for the 4-bit ripple adder: accepts {a, b, cin} operand vectors together with the adder's {sum, cout} result and recomputes the expected result internally.
- Counts pass/fail over a run of NUM_VECTORS vectors and captures the first mismatching vector.
- Sits on the adder's outputs as an in-hardware self-checker; the stimulus source drives it through a valid/ready handshake.

Parameters:
- WIDTH, 4, operand/sum width
- CNT_W, 8, width of pass/fail/index counters
- NUM_VECTORS, 6, vectors per run (1 .. 2^CNT_W-1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse; begins a run from IDLE or DONE
- in_valid  in  1  vector present on a/b/cin/sum/cout
- in_ready  out  1  checker accepts a vector this cycle
- a, b  in  WIDTH  operands
- cin  in  1  carry in
- sum  in  WIDTH  adder sum under test
- cout  in  1  adder carry out under test
- busy  out  1  run in progress (RUN or DRAIN)
- done  out  1  run complete; held until start or rst
- all_pass  out  1  done and fail_cnt==0
- pass_cnt, fail_cnt  out  CNT_W  results of the current run
- err  out  1  sticky; set on first mismatch of the run
- ff_idx  out  CNT_W  0-based index of the first failing vector
- ff_a, ff_b  out  WIDTH  operands of the first failing vector
- ff_cin  out  1  cin of the first failing vector
- ff_got  out  WIDTH+1  {cout,sum} received for the first failing vector
- ff_exp  out  WIDTH+1  {cout,sum} expected for the first failing vector

Behaviour:
- Reset:
  - state=IDLE.
  - All outputs 0, including in_ready, busy, done, all_pass, err, all counters and all ff_* fields.
  - Stage-1 valid flag cleared.
- States:
  - IDLE: in_ready=0; start -> RUN, clearing counters, err and ff_*.
  - RUN: in_ready=1; accepts on in_valid&&in_ready. The accept of vector index NUM_VECTORS-1 -> DRAIN.
  - DRAIN: in_ready=0; one cycle -> DONE.
  - DONE: done=1, in_ready=0; start -> RUN with the same clearing as from IDLE.
- start is ignored in RUN and DRAIN.
- Pipeline:
  - Stage 1 (accept edge E): register a, b, cin, sum, cout and the vector index, and compute exp = a+b+cin at WIDTH+1 bits, zero-extended, no truncation.
  - Stage 2 (edge E+1): compare {cout,sum} against exp.
    - Match: pass_cnt += 1.
    - Mismatch: fail_cnt += 1. If err==0, capture ff_* and set err.
  - Counters are visible after edge E+1, i.e. latency 2 cycles from in_valid sampled high.
- done rises after the edge that completes the last compare, so all counters are final when done==1.
- The vector index increments per accept. It does not wrap within a run because NUM_VECTORS < 2^CNT_W.
- pass_cnt and fail_cnt saturate at all-ones.
- Back-to-back accepts, one per cycle, are supported with no bubbles.
- in_valid is ignored when in_ready==0 (IDLE, DRAIN, DONE); no vector is counted.
- Changing a, b or cin while in_valid==0 has no effect.
- A start pulse coincident with in_valid in IDLE/DONE is not an accept: in_ready is 0 that cycle, and the first accept is possible the following cycle.
- rst mid-run aborts immediately to IDLE with all outputs cleared; the in-flight stage-1 vector is discarded.
- all_pass = done && (fail_cnt==0), registered.
- Only a mismatch on the full WIDTH+1 result counts as a failure; cout-only errors are failures.

Test Plan:
- Reset, start, then 6 correct vectors: (0,3,1,sum=4,co=0), (0,3,0,3,0), (10,2,1,13,0), (12,11,1,8,1), (2,3,0,5,0), (8,3,1,12,0), back-to-back -> done after 2 cycles past the last accept, pass_cnt=6, fail_cnt=0, err=0, all_pass=1.
- Same 6 vectors, but vector 2 reports sum=12 and vector 4 reports sum=4 -> fail_cnt=2, pass_cnt=4, err=1, ff_idx=2, ff_a=10, ff_b=2, ff_cin=1, ff_got=5'h0C, ff_exp=5'h0D, all_pass=0.
- Carry-only error: (12,11,1) reported as sum=8, cout=0 in an otherwise correct run -> fail_cnt=1, ff_got=5'h08, ff_exp=5'h18.
- in_valid toggled with gaps, and in_valid held high in IDLE before start -> only vectors accepted in RUN are counted; the pre-start in_valid is not counted; totals equal 6.
- rst asserted after the 3rd accept -> next cycle all outputs 0 and state IDLE. A new start plus 6 correct vectors gives pass_cnt=6 with no residue from the aborted run.
- From DONE with err=1, pulse start and run 6 correct vectors -> err, fail_cnt and ff_* cleared at start; final all_pass=1.
